// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block: FSM state encoding,
// maximum select width and a one-hot helper.
package scan_decoder_pkg;

    localparam int unsigned SEL_W_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN,
        ST_BLANK
    } state_e;

    function automatic logic [2**SEL_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] i);
        logic [2**SEL_W_MAX-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder with enable; all-zero when disabled.
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 4
) (
    input  logic [SEL_W-1:0]    idx,
    input  logic                en,
    output logic [2**SEL_W-1:0] d
);

    localparam int unsigned N = 2**SEL_W;

    always_comb begin
        d = '0;
        if (en) begin
            d = N'(onehot(SEL_W_MAX'(idx)));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and scanning modes.
// Define SCAN_DECODER_BLANK_EN to insert one blank cycle after every dwell expiry.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [2**SEL_W-1:0] d,
    output logic [SEL_W-1:0]    idx,
    output logic                wrap
);

    localparam int unsigned N        = 2**SEL_W;
    localparam int unsigned CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DCNT_MAX = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    dcnt_q, dcnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     d_q, d_d;
    logic             wrap_q, wrap_d;
    logic             d_en;

    // The decoder sees the next index, so d always equals 1<<idx when non-zero.
    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx (idx_d),
        .en  (d_en),
        .d   (d_d)
    );

    always_comb begin
        state_d = state_q;
        dcnt_d  = '0;
        idx_d   = '0;
        d_en    = 1'b0;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = sel;
            d_en    = 1'b1;
        end else begin
            unique case (state_q)
                ST_SCAN: begin
                    if (dcnt_q < DCNT_MAX) begin
                        dcnt_d = dcnt_q + 1'b1;
                        idx_d  = idx_q;
                        d_en   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
`ifdef SCAN_DECODER_BLANK_EN
                        state_d = ST_BLANK;
`else
                        d_en   = 1'b1;
                        wrap_d = (idx_q == IDX_LAST);
`endif
                    end
                end
`ifdef SCAN_DECODER_BLANK_EN
                ST_BLANK: begin
                    // Index was already advanced on entry to blank.
                    state_d = ST_SCAN;
                    idx_d   = idx_q;
                    d_en    = 1'b1;
                    wrap_d  = (idx_q == '0);
                end
`endif
                default: begin
                    state_d = ST_SCAN;
                    d_en    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            idx_q   <= '0;
            d_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
